// File: rtl/rle_block_decoder.sv
// Rebuilds one 8x8 quantized block from (run, value)/EOB symbols in zigzag order
// and streams it out as 8 raster rows, column 0 in the most significant slice.
module rle_block_decoder #(
   parameter int COEF_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_run,
   input  logic [COEF_W-1:0]     in_val,
   input  logic                  in_eob,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            out_row,
   output logic [8*COEF_W-1:0]   out_data,
   output logic                  blk_done,
   output logic                  err_ovf
);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t            state, state_next;
   logic [6:0]        k, k_next;
   logic [2:0]        r, r_next;
   logic [63:0]       mask, mask_next;
   logic [COEF_W-1:0] coef [64];
   logic [6:0]        pos;
   logic [5:0]        raster;
   logic              wr_en;
   logic              done_next, ovf_next;

   function automatic logic [5:0] zz2raster(input logic [5:0] z);
      zz2raster = 6'd0;
      case (z)
         6'd0:  zz2raster = 6'd0;   6'd1:  zz2raster = 6'd1;   6'd2:  zz2raster = 6'd8;   6'd3:  zz2raster = 6'd16;
         6'd4:  zz2raster = 6'd9;   6'd5:  zz2raster = 6'd2;   6'd6:  zz2raster = 6'd3;   6'd7:  zz2raster = 6'd10;
         6'd8:  zz2raster = 6'd17;  6'd9:  zz2raster = 6'd24;  6'd10: zz2raster = 6'd32;  6'd11: zz2raster = 6'd25;
         6'd12: zz2raster = 6'd18;  6'd13: zz2raster = 6'd11;  6'd14: zz2raster = 6'd4;   6'd15: zz2raster = 6'd5;
         6'd16: zz2raster = 6'd12;  6'd17: zz2raster = 6'd19;  6'd18: zz2raster = 6'd26;  6'd19: zz2raster = 6'd33;
         6'd20: zz2raster = 6'd40;  6'd21: zz2raster = 6'd48;  6'd22: zz2raster = 6'd41;  6'd23: zz2raster = 6'd34;
         6'd24: zz2raster = 6'd27;  6'd25: zz2raster = 6'd20;  6'd26: zz2raster = 6'd13;  6'd27: zz2raster = 6'd6;
         6'd28: zz2raster = 6'd7;   6'd29: zz2raster = 6'd14;  6'd30: zz2raster = 6'd21;  6'd31: zz2raster = 6'd28;
         6'd32: zz2raster = 6'd35;  6'd33: zz2raster = 6'd42;  6'd34: zz2raster = 6'd49;  6'd35: zz2raster = 6'd56;
         6'd36: zz2raster = 6'd57;  6'd37: zz2raster = 6'd50;  6'd38: zz2raster = 6'd43;  6'd39: zz2raster = 6'd36;
         6'd40: zz2raster = 6'd29;  6'd41: zz2raster = 6'd22;  6'd42: zz2raster = 6'd15;  6'd43: zz2raster = 6'd23;
         6'd44: zz2raster = 6'd30;  6'd45: zz2raster = 6'd37;  6'd46: zz2raster = 6'd44;  6'd47: zz2raster = 6'd51;
         6'd48: zz2raster = 6'd58;  6'd49: zz2raster = 6'd59;  6'd50: zz2raster = 6'd52;  6'd51: zz2raster = 6'd45;
         6'd52: zz2raster = 6'd38;  6'd53: zz2raster = 6'd31;  6'd54: zz2raster = 6'd39;  6'd55: zz2raster = 6'd46;
         6'd56: zz2raster = 6'd53;  6'd57: zz2raster = 6'd60;  6'd58: zz2raster = 6'd61;  6'd59: zz2raster = 6'd54;
         6'd60: zz2raster = 6'd47;  6'd61: zz2raster = 6'd55;  6'd62: zz2raster = 6'd62;  6'd63: zz2raster = 6'd63;
         default: zz2raster = 6'd0;
      endcase
   endfunction

   // k never exceeds 63 while filling, so k + 15 fits in 7 bits without wrapping.
   assign pos    = k + {3'b000, in_run};
   assign raster = zz2raster(pos[5:0]);

   always_comb begin
      state_next = state;
      k_next     = k;
      r_next     = r;
      mask_next  = mask;
      wr_en      = 1'b0;
      done_next  = 1'b0;
      ovf_next   = 1'b0;
      in_ready   = (state == FILL);
      out_valid  = (state == DRAIN);
      out_row    = r;
      case (state)
         FILL: begin
            if (in_valid) begin
               if (in_eob) begin
                  state_next = DRAIN;
               end else if (pos <= 7'd63) begin
                  wr_en             = 1'b1;
                  mask_next[raster] = 1'b1;
                  k_next            = pos + 7'd1;
                  if (pos == 7'd63) state_next = DRAIN;
               end else begin
                  ovf_next   = 1'b1;
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (r == 3'd7) begin
                  r_next     = 3'd0;
                  k_next     = 7'd0;
                  mask_next  = 64'd0;
                  done_next  = 1'b1;
                  state_next = FILL;
               end else begin
                  r_next = r + 3'd1;
               end
            end
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FILL;
         k        <= 7'd0;
         r        <= 3'd0;
         mask     <= 64'd0;
         blk_done <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         state    <= state_next;
         k        <= k_next;
         r        <= r_next;
         mask     <= mask_next;
         blk_done <= done_next;
         err_ovf  <= ovf_next;
      end
   end

   // The mask, not a clear pass, hides stale coefficients from the previous block.
   always_ff @(posedge clk) begin
      if (wr_en) coef[raster] <= in_val;
   end

   always_comb begin
      out_data = '0;
      for (int c = 0; c < 8; c++) begin
         if (mask[{r, 3'(c)}])
            out_data[(8-c)*COEF_W-1 -: COEF_W] = coef[{r, 3'(c)}];
      end
   end

endmodule

// File: tb/tb_rle_block_decoder.sv
// Scoreboard bench for rle_block_decoder: a zigzag model fills expected rows as
// symbols are driven, and the drained rows are popped and compared.
module tb_rle_block_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_run = 4'd0;
   logic [7:0]  in_val = 8'd0;
   logic        in_eob = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_row;
   logic [63:0] out_data;
   logic        blk_done;
   logic        err_ovf;

   typedef struct {
      logic [2:0]  row;
      logic [63:0] data;
   } row_t;

   row_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] mcoef[64];
   int         mk = 0;
   int         zz_tab[64];

   rle_block_decoder #(.COEF_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_run(in_run), .in_val(in_val), .in_eob(in_eob),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_data(out_data),
      .blk_done(blk_done), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < 64; i++) mcoef[i] = 8'd0;
      mk = 0;
   endtask

   task automatic pushBlock();
      row_t e;
      for (int rr = 0; rr < 8; rr++) begin
         e.row  = 3'(rr);
         e.data = 64'd0;
         for (int c = 0; c < 8; c++) e.data[(8-c)*8-1 -: 8] = mcoef[rr*8+c];
         sb.push_back(e);
      end
      modelClear();
   endtask

   task automatic applyStimulus(input int run, input logic [7:0] val, input logic eob);
      int p;
      checkOutput("in_ready_fill", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_run   = 4'(run);
      in_val   = val;
      in_eob   = eob;
      if (eob) begin
         pushBlock();
      end else begin
         p = mk + run;
         if (p <= 63) begin
            mcoef[zz_tab[p]] = val;
            mk = p + 1;
            if (p == 63) pushBlock();
         end else begin
            pushBlock();
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_eob   = 1'b0;
   endtask

   task automatic drainBlock(input int stall_row, input int stall_n, input int abort_row);
      row_t e;
      int   wait_n;
      out_ready = 1'b1;
      for (int row = 0; row < 8; row++) begin
         wait_n = 0;
         while (out_valid !== 1'b1 && wait_n < 10) begin
            @(posedge clk); #1;
            wait_n++;
         end
         checkOutput("out_valid", 64'(out_valid), 64'd1);
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_underflow row=%0d", row);
            out_ready = 1'b0;
            return;
         end
         e = sb.pop_front();
         checkOutput("out_row", 64'(out_row), 64'(e.row));
         checkOutput("out_data", out_data, e.data);
         checkOutput("in_ready_drain", 64'(in_ready), 64'd0);
         checkOutput("blk_done_idle", 64'(blk_done), 64'd0);
         if (row > 0) checkOutput("err_ovf_idle", 64'(err_ovf), 64'd0);
         if (row == abort_row) begin
            reset = 1'b0;
            #1;
            checkOutput("out_valid_reset", 64'(out_valid), 64'd0);
            checkOutput("in_ready_reset", 64'(in_ready), 64'd1);
            out_ready = 1'b0;
            sb.delete();
            return;
         end
         if (row == stall_row) begin
            out_ready = 1'b0;
            repeat (stall_n) begin
               @(posedge clk); #1;
               checkOutput("stall_row", 64'(out_row), 64'(e.row));
               checkOutput("stall_data", out_data, e.data);
               checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
               checkOutput("stall_valid", 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      checkOutput("blk_done_pulse", 64'(blk_done), 64'd1);
      checkOutput("out_valid_after", 64'(out_valid), 64'd0);
      checkOutput("in_ready_after", 64'(in_ready), 64'd1);
      out_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("blk_done_once", 64'(blk_done), 64'd0);
   endtask

   initial begin
      int n, lo, hi;
      n = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int rw = hi; rw >= lo; rw--) begin zz_tab[n] = rw*8 + (s-rw); n++; end
         end else begin
            for (int rw = lo; rw <= hi; rw++) begin zz_tab[n] = rw*8 + (s-rw); n++; end
         end
      end
      modelClear();

      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_row", 64'(out_row), 64'd0);
      checkOutput("rst_blk_done", 64'(blk_done), 64'd0);
      checkOutput("rst_err_ovf", 64'(err_ovf), 64'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      $display("[TB] T1 EOB only");
      applyStimulus(0, 8'd0, 1'b1);
      drainBlock(-1, 0, -1);

      $display("[TB] T2 small block");
      applyStimulus(0, 8'h05, 1'b0);
      applyStimulus(0, 8'hFD, 1'b0);
      applyStimulus(1, 8'h07, 1'b0);
      applyStimulus(0, 8'h00, 1'b1);
      drainBlock(-1, 0, -1);

      $display("[TB] T3 full block without EOB");
      for (int i = 1; i <= 64; i++) applyStimulus(0, 8'(i), 1'b0);
      drainBlock(-1, 0, -1);

      $display("[TB] T4 overflow");
      applyStimulus(15, 8'd1, 1'b0);
      applyStimulus(15, 8'd1, 1'b0);
      applyStimulus(15, 8'd1, 1'b0);
      applyStimulus(0, 8'd2, 1'b0);
      applyStimulus(15, 8'd9, 1'b0);
      checkOutput("err_ovf_pulse", 64'(err_ovf), 64'd1);
      drainBlock(-1, 0, -1);

      $display("[TB] T5 backpressure at row 3");
      for (int i = 0; i < 10; i++)
         applyStimulus(int'($urandom_range(0, 5)), 8'($urandom_range(1, 255)), 1'b0);
      applyStimulus(0, 8'd0, 1'b1);
      drainBlock(3, 3, -1);

      $display("[TB] T6 reset during drain");
      applyStimulus(2, 8'h11, 1'b0);
      applyStimulus(0, 8'h22, 1'b0);
      applyStimulus(0, 8'd0, 1'b1);
      drainBlock(-1, 0, 4);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
      applyStimulus(0, 8'd0, 1'b1);
      drainBlock(-1, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
